ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter, the send side of the keyboard link whose receive path is built from our synchronous-reset D flip-flop stages. It takes one command byte per request, such as 0xED (set LEDs) or 0xFF (reset), and serialises it onto the open-drain PS2 clock/data lines. It runs the full request-to-send, bit-shift and acknowledge sequence. It sits beside the receiver in the keyboard interface and asserts `tx_busy` so the receiver ignores line activity during a transmission.

## Interface
- `INHIBIT_CYCLES`, 12000: cycles the clock line is held low for request-to-send (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 2000000: maximum wait for any device falling edge, or for the final line release (20 ms).
- `FILTER_LEN`, 8: consecutive agreeing synchronised samples required to change the filtered PS2 clock.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `tx_start` input 1: one-cycle request to send `tx_data`.
- `tx_data` input 8: command byte, latched on the cycle `tx_start` is accepted.
- `ps2c_in` input 1: raw PS2 clock line (asynchronous).
- `ps2d_in` input 1: raw PS2 data line (asynchronous).
- `ps2c_oe` output 1: 1 pulls the PS2 clock line low; 0 releases it.
- `ps2d_oe` output 1: 1 pulls the PS2 data line low; 0 releases it.
- `tx_busy` output 1: high from the accept cycle until `tx_done_tick`, inclusive.
- `tx_done_tick` output 1: one-cycle pulse when the transaction ends.
- `tx_err` output 1: valid on `tx_done_tick` and held until the next accept. 1 means NACK or timeout.

## Operation
- Reset values:
  - `ps2c_oe` = 0, `ps2d_oe` = 0.
  - `tx_busy` = 0, `tx_done_tick` = 0, `tx_err` = 0.
  - State = IDLE, all counters = 0.
- `tx_start` is accepted only in IDLE. It is ignored while `tx_busy` = 1.
- On accept, the shift frame is loaded, in send order:
  - data bits 0..7 (LSB first),
  - parity = ~^`tx_data` (odd parity),
  - stop = 1.
- States:
  - IDLE → RTS on accept.
  - RTS: `ps2c_oe` = 1 for INHIBIT_CYCLES cycles → START.
  - START: `ps2d_oe` = 1 (start bit 0) with `ps2c_oe` still 1, for exactly 1 cycle → SHIFT with `ps2c_oe` = 0.
  - SHIFT: each filtered falling edge presents the next frame bit, with `ps2d_oe` = ~bit.
    - Falling edges 1–8 present data bits 0–7.
    - Falling edge 9 presents parity.
    - Falling edge 10 presents stop: `ps2d_oe` = 0.
    - After falling edge 10 → ACK.
  - ACK: the next filtered falling edge samples synchronised `ps2d`. 0 = ACK, 1 = NACK → WAIT_REL.
  - WAIT_REL: wait until filtered clock and synchronised data are both 1 → DONE.
  - DONE: `tx_done_tick` = 1 for one cycle, `tx_err` = NACK flag → IDLE.
- Timeout:
  - The counter restarts on entry to SHIFT and on every filtered falling edge.
  - In SHIFT, ACK or WAIT_REL, reaching TIMEOUT_CYCLES forces both `oe` = 0 and `tx_err` = 1 → DONE.
- Reset asserted mid-transaction: both lines are released on that edge, with no done pulse.
- The device pulling data low during RTS does not abort; the sequence continues.

## Timing
- Input path:
  - 2-FF synchroniser on each line.
  - Clock filter: the filtered level changes after FILTER_LEN equal samples.
  - Falling-edge tick one cycle after the filtered clock goes 1→0.
- Edge-to-output latency: `ps2d_oe` updates on the cycle after the falling-edge tick. This is at most 2 + FILTER_LEN + 2 cycles after the raw edge, well inside the device's clock-low half period.
- Accept to first `ps2d_oe` = 1: INHIBIT_CYCLES + 1 cycles.
- The clock is released exactly 1 cycle after data is pulled low.
- `tx_done_tick` arrives 1 cycle after the WAIT_REL exit condition.
- A new `tx_start` is accepted no earlier than the cycle after `tx_done_tick`.

## Structure
- Shared package `ps2_pkg`:
  - state encoding (IDLE, RTS, START, SHIFT, ACK, WAIT_REL, DONE),
  - frame length constant 10,
  - parameter defaults, shared with the PS/2 receiver.
- Sub-module `ps2_line_filter`:
  - synchroniser, FILTER_LEN clock filter and falling-edge tick,
  - reusable by the receiver.
- Top level: FSM, 10-bit frame shift register, 4-bit edge counter, one timer counter shared by RTS and timeout.

## Test plan
Bench parameters: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 500, FILTER_LEN = 4. The device model clocks with a 40-cycle period.

- `tx_data` = 0xED, device ACKs:
  - device samples 0, 1,0,1,1,0,1,1,1, 1 (parity), 1 (stop) on its rising edges;
  - one `tx_done_tick`, `tx_err` = 0;
  - `ps2c_oe` high exactly 21 cycles.
- `tx_data` = 0x00: parity bit sampled = 1, stop = 1, ACK → `tx_err` = 0.
- Device drives data high in the ACK slot → `tx_done_tick` with `tx_err` = 1.
- Device never clocks after RTS:
  - both `oe` = 0 and `tx_err` = 1 after START + 500 cycles;
  - `tx_busy` falls after the tick.
- Second `tx_start` (0xFF) mid-frame → ignored; only 0xED is observed.
- `rst` asserted after data bit 4 → both `oe` = 0 and `tx_busy` = 0 on the next edge; no done pulse. A following 0xF4 then sends correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the receiver.
// Holds the transmitter state encoding, frame length, parameter defaults
// and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_SHIFT,
    S_ACK,
    S_WAIT_REL,
    S_DONE
  } tx_state_e;

  // Data bits 0..7, parity, stop.
  localparam int unsigned FRAME_LEN = 10;

  localparam int unsigned INHIBIT_CYCLES_DEF = 12000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;
  localparam int unsigned FILTER_LEN_DEF     = 8;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on clock and data, a
// FILTER_LEN-sample agreement filter on the clock, and a falling-edge tick.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   ps2c_i        raw PS2 clock line (asynchronous)
//   ps2d_i        raw PS2 data line (asynchronous)
//   clk_filt_o    filtered PS2 clock level
//   dat_sync_o    synchronised PS2 data level
//   fall_tick_o   one-cycle pulse the cycle after clk_filt_o goes 1->0
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic clk_filt_o,
  output logic dat_sync_o,
  output logic fall_tick_o
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    csync_q, dsync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (csync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = csync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      csync_q <= '1;
      dsync_q <= '1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      csync_q <= {csync_q[0], ps2c_i};
      dsync_q <= {dsync_q[0], ps2d_i};
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      fall_q  <= filt_q & ~filt_d;
    end
  end

  assign clk_filt_o  = filt_q;
  assign dat_sync_o  = dsync_q[1];
  assign fall_tick_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 10-bit frame shift on
// device falling edges, acknowledge sampling and line-release wait, with a
// timeout on every device-driven wait.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tx_start      one-cycle send request (accepted only when idle)
//   tx_data       command byte, latched on accept
//   ps2c_in       raw PS2 clock line;  ps2d_in  raw PS2 data line
//   ps2c_oe       1 pulls PS2 clock low; ps2d_oe  1 pulls PS2 data low
//   tx_busy       high from accept through the done tick
//   tx_done_tick  one-cycle end-of-transaction pulse
//   tx_err        NACK or timeout, valid on done and held until next accept
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int unsigned TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  tx_state_e               state_q, state_d;
  logic [FRAME_LEN-1:0]    frame_q, frame_d;
  logic [3:0]              bitcnt_q, bitcnt_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    ps2c_oe_q, ps2c_oe_d;
  logic                    ps2d_oe_q, ps2d_oe_d;
  logic                    nack_q, nack_d;
  logic                    err_q, err_d;

  logic clk_filt, dat_sync, fall_tick;
  logic timed_out;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .rst         (rst),
    .ps2c_i      (ps2c_in),
    .ps2d_i      (ps2d_in),
    .clk_filt_o  (clk_filt),
    .dat_sync_o  (dat_sync),
    .fall_tick_o (fall_tick)
  );

  assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Line enables are registered from the next state so the open-drain
  // outputs never glitch on state decode.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bitcnt_d  = bitcnt_q;
    timer_d   = timer_q;
    ps2c_oe_d = ps2c_oe_q;
    ps2d_oe_d = ps2d_oe_q;
    nack_d    = nack_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        if (tx_start) begin
          state_d   = S_RTS;
          frame_d   = {1'b1, odd_parity(tx_data), tx_data};
          bitcnt_d  = '0;
          timer_d   = '0;
          nack_d    = 1'b0;
          err_d     = 1'b0;
          ps2c_oe_d = 1'b1;
        end
      end

      S_RTS: begin
        ps2c_oe_d = 1'b1;
        if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
          state_d   = S_START;
          timer_d   = '0;
          ps2d_oe_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_START: begin
        state_d   = S_SHIFT;
        timer_d   = '0;
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b1;
      end

      S_SHIFT: begin
        if (fall_tick) begin
          ps2d_oe_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[FRAME_LEN-1:1]};
          bitcnt_d  = bitcnt_q + 4'd1;
          timer_d   = '0;
          if (bitcnt_q == 4'(FRAME_LEN - 1)) begin
            state_d = S_ACK;
          end
        end else if (timed_out) begin
          state_d   = S_DONE;
          ps2d_oe_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_ACK: begin
        ps2d_oe_d = 1'b0;
        if (fall_tick) begin
          nack_d  = dat_sync;
          timer_d = '0;
          state_d = S_WAIT_REL;
        end else if (timed_out) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAIT_REL: begin
        if (clk_filt && dat_sync) begin
          state_d = S_DONE;
          err_d   = nack_q;
        end else if (timed_out) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bitcnt_q  <= '0;
      timer_q   <= '0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      nack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bitcnt_q  <= bitcnt_d;
      timer_q   <= timer_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
      nack_q    <= nack_d;
      err_q     <= err_d;
    end
  end

  assign ps2c_oe      = ps2c_oe_q;
  assign ps2d_oe      = ps2d_oe_q;
  assign tx_busy      = (state_q != S_IDLE);
  assign tx_done_tick = (state_q == S_DONE);
  assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on
// wired-AND clock/data lines (40-cycle device clock period).
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TO  = 500;
  localparam int unsigned FL  = 4;

  logic       clk = 1'b0;
  logic       rst, tx_start;
  logic [7:0] tx_data;
  logic       ps2c_oe, ps2d_oe, tx_busy, tx_done_tick, tx_err;
  logic       dev_clk, dev_dat;
  logic       ps2c_line, ps2d_line;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned mon_c = 0, mon_d = 0, mon_done = 0;
  int unsigned c0, d0, done0;
  logic [10:0] bits;

  always #5 clk = ~clk;

  assign ps2c_line = dev_clk & ~ps2c_oe;
  assign ps2d_line = dev_dat & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .ps2c_in      (ps2c_line),
    .ps2d_in      (ps2d_line),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx_err       (tx_err)
  );

  always @(negedge clk) begin
    if (ps2c_oe)      mon_c    <= mon_c + 1;
    if (ps2d_oe)      mon_d    <= mon_d + 1;
    if (tx_done_tick) mon_done <= mon_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int k;
    k = 0;
    while (!tx_done_tick && k < limit) begin
      tick();
      k++;
    end
    check(tag, tx_done_tick, 1'b1);
  endtask

  // Device side: samples start, then 10 rising-edge samples, then ACK slot.
  // inject_at: issue a 0xFF tx_start during that clock-low phase.
  // rst_at: pulse rst after that rising edge and abandon the frame.
  task automatic dev_frame(input logic nack, input int inject_at, input int rst_at,
                           output logic [10:0] fb);
    int k;
    fb = '0;
    k  = 0;
    while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && k < 200) begin
      tick();
      k++;
    end
    check("dev_rts_release", {ps2c_oe, ps2d_oe}, 2'b01);
    ticks(15);
    fb[0] = ps2d_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      if (i == inject_at) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        ticks(19);
      end else begin
        ticks(20);
      end
      dev_clk = 1'b1;
      fb[i]   = ps2d_line;
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_oe", {ps2c_oe, ps2d_oe}, 2'b00);
        check("rst_mid_busy", tx_busy, 1'b0);
        return;
      end
      ticks(20);
    end
    dev_dat = nack;
    ticks(5);
    dev_clk = 1'b0;
    ticks(20);
    dev_clk = 1'b1;
    ticks(5);
    dev_dat = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    ticks(3);
    check("rst_c_oe", ps2c_oe, 1'b0);
    check("rst_d_oe", ps2d_oe, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done_tick, 1'b0);
    check("rst_err", tx_err, 1'b0);
    rst = 1'b0;
    ticks(10);

    // 0xED with ACK, plus RTS/START boundary timing
    c0 = mon_c; done0 = mon_done;
    send(8'hED);
    check("ed_busy", tx_busy, 1'b1);
    ticks(19);
    check("ed_rts_end", {ps2c_oe, ps2d_oe}, 2'b10);
    tick();
    check("ed_start", {ps2c_oe, ps2d_oe}, 2'b11);
    tick();
    check("ed_shift", {ps2c_oe, ps2d_oe}, 2'b01);
    dev_frame(1'b0, 0, 0, bits);
    check("ed_frame", bits, {1'b1, 1'b1, 8'hED, 1'b0});
    wait_done(200, "ed_done");
    check("ed_err", tx_err, 1'b0);
    tick();
    check("ed_busy_low", tx_busy, 1'b0);
    check("ed_c_oe_cycles", mon_c - c0, 21);
    check("ed_done_count", mon_done - done0, 1);
    ticks(20);

    // 0x00: parity 1
    send(8'h00);
    dev_frame(1'b0, 0, 0, bits);
    check("z_frame", bits, {1'b1, 1'b1, 8'h00, 1'b0});
    wait_done(200, "z_done");
    check("z_err", tx_err, 1'b0);
    ticks(20);

    // NACK
    send(8'h55);
    dev_frame(1'b1, 0, 0, bits);
    check("nk_frame", bits, {1'b1, 1'b1, 8'h55, 1'b0});
    wait_done(200, "nk_done");
    check("nk_err", tx_err, 1'b1);
    ticks(20);

    // Device never clocks: timeout
    d0 = mon_d;
    send(8'h12);
    wait_done(700, "to_done");
    check("to_err", tx_err, 1'b1);
    check("to_oe", {ps2c_oe, ps2d_oe}, 2'b00);
    check("to_d_oe_cycles", mon_d - d0, 501);
    tick();
    check("to_busy_low", tx_busy, 1'b0);
    ticks(20);

    // Second request mid-frame is ignored
    done0 = mon_done;
    send(8'hED);
    dev_frame(1'b0, 4, 0, bits);
    check("ig_frame", bits, {1'b1, 1'b1, 8'hED, 1'b0});
    wait_done(200, "ig_done");
    check("ig_err", tx_err, 1'b0);
    ticks(30);
    check("ig_done_count", mon_done - done0, 1);
    check("ig_idle", {tx_busy, ps2c_oe}, 2'b00);

    // Reset after data bit 4, then 0xF4
    done0 = mon_done;
    send(8'hED);
    dev_frame(1'b0, 0, 5, bits);
    ticks(50);
    check("rs_no_done", mon_done - done0, 0);
    send(8'hF4);
    dev_frame(1'b0, 0, 0, bits);
    check("f4_frame", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
    wait_done(200, "f4_done");
    check("f4_err", tx_err, 1'b0);
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
